// File: rtl/rr_grant_arbiter_if.sv
// Handshake bundle between the round-robin grant arbiter, its requesters and
// the consuming issue stage.
// master: arbiter side (drives the grant). slave: requester/consumer side.
// RR_ARB_LOCK_EN adds the lock signal to the bundle.
interface rr_grant_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0] request;
    logic               grant_ready;
`ifdef RR_ARB_LOCK_EN
    logic               lock;
`endif
    logic [NUM_REQ-1:0] grantOH;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;

`ifdef RR_ARB_LOCK_EN
    modport master (
        input  request, grant_ready, lock,
        output grantOH, grant_idx, grant_valid
    );

    modport slave (
        output request, grant_ready, lock,
        input  grantOH, grant_idx, grant_valid
    );
`else
    modport master (
        input  request, grant_ready,
        output grantOH, grant_idx, grant_valid
    );

    modport slave (
        output request, grant_ready,
        input  grantOH, grant_idx, grant_valid
    );
`endif
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for the SM issue path: picks one of NUM_REQ warps,
// registers a one-hot grant plus binary index, holds it until the issue stage
// accepts it, then rotates priority past the accepted warp.
// Optional feature macro: RR_ARB_LOCK_EN (owner lock on accept).
module rr_grant_arbiter #(
    parameter int unsigned NUM_REQ = 4,                 // warps per SM
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input logic                clk,
    input logic                reset,
    rr_grant_arbiter_if.master bus
);

    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic               accept;
    logic               arb_en;
    logic               lock_acc;
    logic               keep_owner;

    logic               found;
    logic [IDX_W-1:0]   win;
    logic [IDX_W:0]     sum;
    logic [IDX_W-1:0]   cand;

    // Handshake decode and priority pointer update on accept.
    always_comb begin
        accept = valid_q & bus.grant_ready;
        arb_en = ~valid_q | bus.grant_ready;
`ifdef RR_ARB_LOCK_EN
        lock_acc   = accept & bus.lock;
        keep_owner = lock_acc & bus.request[idx_q];
`else
        lock_acc   = 1'b0;
        keep_owner = 1'b0;
`endif
        ptr_d = ptr_q;
        if (accept && !lock_acc) begin
            ptr_d = idx_q;
        end
    end

    // Search ptr+1, ptr+2, ... wrapping with an explicit compare so that
    // non-power-of-two NUM_REQ never lands on a nonexistent requester.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, ptr_d} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!found && bus.request[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next grant: hold, re-grant a locked owner, or take the search winner.
    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        if (arb_en) begin
            if (keep_owner) begin
                valid_d = 1'b1;
                idx_d   = idx_q;
            end else begin
                valid_d = found;
                idx_d   = found ? win : '0;
            end
        end
        grant_d = '0;
        if (valid_d) begin
            grant_d[idx_d] = 1'b1;
        end
    end

    // Grant and pointer registers; reset leaves requester 0 highest priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
        end else begin
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.grantOH     = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: directed scenarios followed by
// randomized traffic compared against a behavioural round-robin model.
module tb_rr_grant_arbiter;
`ifdef RR_ARB_LOCK_EN
    localparam int N = 5;
    localparam bit LOCK_ON = 1'b1;
`else
    localparam int N = 4;
    localparam bit LOCK_ON = 1'b0;
`endif
    localparam int W = $clog2(N);

    logic clk;
    logic reset;

    rr_grant_arbiter_if #(.NUM_REQ(N), .IDX_W(W)) bus ();

    rr_grant_arbiter #(.NUM_REQ(N), .IDX_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: last accepted requester (priority pointer) and current grant.
    int m_ptr;
    bit m_valid;
    int m_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = N - 1;
        m_valid = 1'b0;
        m_idx   = 0;
    endtask

    function automatic logic [31:0] exp_oh();
        logic [31:0] v;
        v = '0;
        if (m_valid) v[m_idx] = 1'b1;
        return v;
    endfunction

    // Apply one clock worth of the rules to the model using the current inputs.
    task automatic model_next();
        bit lk;
        int p;
`ifdef RR_ARB_LOCK_EN
        lk = bus.lock;
`else
        lk = 1'b0;
`endif
        if (m_valid && !bus.grant_ready) return;
        p = m_ptr;
        if (m_valid && bus.grant_ready) begin
            if (LOCK_ON && lk && bus.request[m_idx]) return;
            if (!(LOCK_ON && lk)) p = m_idx;
        end
        m_ptr   = p;
        m_valid = 1'b0;
        m_idx   = 0;
        for (int off = 1; off <= N; off++) begin
            int c;
            c = (p + off) % N;
            if (bus.request[c]) begin
                m_valid = 1'b1;
                m_idx   = c;
                break;
            end
        end
    endtask

    task automatic step();
        if (bus.grant_valid && !bus.grant_ready)
            check("req_held", 32'(bus.request[bus.grant_idx]), 32'd1);
        model_next();
        @(posedge clk);
        #1;
        check("valid", 32'(bus.grant_valid), 32'(m_valid));
        check("idx", 32'(bus.grant_idx), 32'(m_idx));
        check("oh", 32'(bus.grantOH), exp_oh());
        check("onehot0", 32'($countones(bus.grantOH) <= 1), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] r;
        logic [N-1:0] req;

        reset = 1'b1;
        bus.request = '0;
        bus.grant_ready = 1'b0;
`ifdef RR_ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.grant_valid), 32'd0);
        check("rst_idx", 32'(bus.grant_idx), 32'd0);
        check("rst_oh", 32'(bus.grantOH), 32'd0);
        reset = 1'b0;
        model_reset();

        // All requesting, always ready: strict rotation starting at 0.
        bus.request = '1;
        bus.grant_ready = 1'b1;
        for (int k = 0; k <= N; k++) begin
            step();
            check("t1_seq", 32'(bus.grant_idx), 32'(k % N));
        end

        // Hold while not ready, then rotate past the accepted owner.
        do_reset();
        bus.request = N'(4'b0101);
        bus.grant_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t2_hold", 32'(bus.grantOH), 32'd1);
            bus.request = N'(4'b0101) | N'(k);
        end
        bus.request = N'(4'b0101);
        bus.grant_ready = 1'b1;
        step();
        check("t2_next", 32'(bus.grantOH), 32'b0100);

        // Lone requester re-granted every cycle, then drop to idle.
        do_reset();
        bus.request = N'(4'b0010);
        bus.grant_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t3_lone", 32'(bus.grantOH), 32'b0010);
        end
        bus.request = '0;
        step();
        check("t3_idle_v", 32'(bus.grant_valid), 32'd0);
        check("t3_idle_oh", 32'(bus.grantOH), 32'd0);

        // Wrap-around after accepting requester 2.
        do_reset();
        bus.request = N'(4'b0100);
        bus.grant_ready = 1'b1;
        step();
        check("t4_pre", 32'(bus.grant_idx), 32'd2);
        bus.request = N'(4'b0011);
        step();
        check("t4_wrap0", 32'(bus.grant_idx), 32'd0);
        step();
        check("t4_wrap1", 32'(bus.grant_idx), 32'd1);

        // Asynchronous reset while holding a grant.
        do_reset();
        bus.request = '1;
        bus.grant_ready = 1'b0;
        step();
        check("t5_pre", 32'(bus.grant_valid), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("t5_async_v", 32'(bus.grant_valid), 32'd0);
        check("t5_async_oh", 32'(bus.grantOH), 32'd0);
        check("t5_async_idx", 32'(bus.grant_idx), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.request = N'(4'b1000);
        step();
        check("t5_after", 32'(bus.grantOH), 32'b1000);

`ifdef RR_ARB_LOCK_EN
        // Lock keeps owner 1 across three accepts, then rotation resumes.
        do_reset();
        bus.request = '1;
        bus.grant_ready = 1'b1;
        bus.lock = 1'b0;
        step();
        step();
        check("t6_first", 32'(bus.grant_idx), 32'd1);
        bus.lock = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t6_locked", 32'(bus.grant_idx), 32'd1);
        end
        bus.lock = 1'b0;
        step();
        check("t6_release", 32'(bus.grant_idx), 32'd2);
`endif

        // Randomized traffic; a granted, unaccepted request is never dropped.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bus.grant_ready = ($urandom_range(0, 3) != 0);
            r = $urandom;
            req = r[N-1:0];
            if ($urandom_range(0, 7) == 0) req = '0;
            if (m_valid && !bus.grant_ready) req[m_idx] = 1'b1;
            bus.request = req;
`ifdef RR_ARB_LOCK_EN
            bus.lock = ($urandom_range(0, 2) == 0);
`endif
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
